// File: rtl/seg_scan_mux_pkg.sv
// seg_pkg: shared types and constants for the 7-segment scan controller.
//   state_t     - scan FSM states
//   SEG_BLANK   - all segments off (active-low)
//   SEG_TABLE   - active-low {g,f,e,d,c,b,a} patterns for values 0..F
//   seg_encode  - value -> segment pattern, blanking 10..15 when hex is off
package seg_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Entry n holds the pattern for value n (packed, entry 15 is leftmost).
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
    7'h03, 7'h08, 7'h18, 7'h00,   // b A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
  };

  function automatic logic [6:0] seg_encode(input logic [3:0] value,
                                            input logic       hex_en);
    if (!hex_en && (value > 4'd9)) begin
      return SEG_BLANK;
    end
    return SEG_TABLE[value];
  endfunction

endpackage

// File: rtl/seg_scan_mux_if.sv
// seg_scan_mux_if: digit sources in, board pins out.
//   enable      - 1 = scan, 0 = display dark
//   digits      - 4 bits per digit, digit 0 rightmost
//   dp_in       - decimal point request per digit
//   blink_mask  - 1 = digit blinks
//   anode       - active-low digit select
//   segs        - active-low {g,f,e,d,c,b,a}
//   dp_n        - active-low decimal point
//   frame_start - high while slot 0 is displayed
// master = datapath side, slave = scan controller.
interface seg_scan_mux_if #(
  parameter int unsigned NUM_DIGITS = 4
);
  logic                      enable;
  logic [4*NUM_DIGITS-1:0]   digits;
  logic [NUM_DIGITS-1:0]     dp_in;
  logic [NUM_DIGITS-1:0]     blink_mask;
  logic [NUM_DIGITS-1:0]     anode;
  logic [6:0]                segs;
  logic                      dp_n;
  logic                      frame_start;

  modport master (
    output enable, digits, dp_in, blink_mask,
    input  anode, segs, dp_n, frame_start
  );

  modport slave (
    input  enable, digits, dp_in, blink_mask,
    output anode, segs, dp_n, frame_start
  );
endinterface

// File: rtl/seg_scan_mux_seg7_decode.sv
// seg7_decode: combinational 4-bit value -> active-low 7-segment pattern.
//   value - digit value 0..15
//   segs  - active-low {g,f,e,d,c,b,a}; 10..15 blank when HEX_EN = 0
module seg7_decode
  import seg_pkg::*;
#(
  parameter int unsigned HEX_EN = 1
) (
  input  logic [3:0] value,
  output logic [6:0] segs
);

  always_comb begin
    segs = seg_encode(value, HEX_EN != 0);
  end

endmodule

// File: rtl/seg_scan_mux.sv
// seg_scan_mux: N-digit time-multiplexed 7-segment scan controller.
//   clk_70hz - scan clock, one digit slot per cycle
//   reset    - asynchronous, active-high
//   bus      - seg_scan_mux_if slave: digit/dp/blink inputs, anode/segs/dp_n/
//              frame_start outputs
// Inputs are snapshotted at frame boundaries so a frame never mixes old and
// new values. Outputs are combinational from registered state.
module seg_scan_mux
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned HEX_EN       = 1,
  parameter int unsigned BLANK_LZ     = 1,
  parameter int unsigned BLINK_FRAMES = 16
) (
  input  logic            clk_70hz,
  input  logic            reset,
  seg_scan_mux_if.slave   bus
);

  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned FC_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(BLINK_FRAMES - 1);

  state_t                  state, state_next;
  logic [IDX_W-1:0]        idx, idx_next;
  logic [FC_W-1:0]         frame_cnt, frame_cnt_next;
  logic                    blink_phase, blink_phase_next;
  logic                    load;

  logic [4*NUM_DIGITS-1:0] snap_digits;
  logic [NUM_DIGITS-1:0]   snap_dp;
  logic [NUM_DIGITS-1:0]   snap_blink;

  always_ff @(posedge clk_70hz or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      idx         <= '0;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
      snap_digits <= '0;
      snap_dp     <= '0;
      snap_blink  <= '0;
    end else begin
      state       <= state_next;
      idx         <= idx_next;
      frame_cnt   <= frame_cnt_next;
      blink_phase <= blink_phase_next;
      if (load) begin
        snap_digits <= bus.digits;
        snap_dp     <= bus.dp_in;
        snap_blink  <= bus.blink_mask;
      end
    end
  end

  always_comb begin
    state_next       = state;
    idx_next         = idx;
    frame_cnt_next   = frame_cnt;
    blink_phase_next = blink_phase;
    load             = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.enable) begin
          state_next = SCAN;
          idx_next   = '0;
          load       = 1'b1;
        end
      end
      SCAN: begin
        if (!bus.enable) begin
          state_next = IDLE;
          idx_next   = '0;
        end else if (idx == IDX_LAST) begin
          idx_next = '0;
          load     = 1'b1;
          if (frame_cnt == FC_LAST) begin
            frame_cnt_next   = '0;
            blink_phase_next = ~blink_phase;
          end else begin
            frame_cnt_next = frame_cnt + FC_W'(1);
          end
        end else begin
          idx_next = idx + IDX_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
        idx_next   = '0;
      end
    endcase
  end

  // lz[i] is set when snapshot digits i..NUM_DIGITS-1 are all zero; built
  // from the most significant digit downward. Digit 0 is never blanked.
  logic [NUM_DIGITS-1:0] lz;
  logic                  zero_run;

  always_comb begin
    lz       = '0;
    zero_run = 1'b1;
    for (int unsigned i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_run = zero_run & (snap_digits[4*i +: 4] == 4'd0);
      lz[i]    = zero_run;
    end
  end

  logic [3:0] digit_sel;
  logic [6:0] dec_segs;

  always_comb begin
    digit_sel = snap_digits[4*int'(idx) +: 4];
  end

  seg7_decode #(
    .HEX_EN (HEX_EN)
  ) u_decode (
    .value (digit_sel),
    .segs  (dec_segs)
  );

  logic [NUM_DIGITS-1:0] anode_o;
  logic [6:0]            segs_o;
  logic                  dp_n_o;
  logic                  frame_start_o;
  logic                  blanked;
  logic                  suppressed;

  always_comb begin
    anode_o       = '1;
    segs_o        = SEG_BLANK;
    dp_n_o        = 1'b1;
    frame_start_o = 1'b0;
    blanked       = (BLANK_LZ != 0) && lz[idx];
    suppressed    = blink_phase && snap_blink[idx];
    if (state == SCAN) begin
      frame_start_o = (idx == '0);
      if (!suppressed) begin
        anode_o[idx] = 1'b0;
        segs_o       = blanked ? SEG_BLANK : dec_segs;
        dp_n_o       = ~snap_dp[idx];
      end
    end
  end

  assign bus.anode       = anode_o;
  assign bus.segs        = segs_o;
  assign bus.dp_n        = dp_n_o;
  assign bus.frame_start = frame_start_o;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Scoreboard bench for seg_scan_mux. Two instances share stimulus:
//   dut_a: HEX_EN=1, BLANK_LZ=1, BLINK_FRAMES=2
//   dut_b: HEX_EN=0, BLANK_LZ=0, BLINK_FRAMES=16
// The driver pushes hand-computed expectations; the monitor pops and compares
// on the falling edge (or immediately on chk_now for between-edge checks).
module tb_seg_scan_mux;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] sg;
    logic       dp;
    logic       fs;
  } obs_t;

  typedef struct {
    string name;
    obs_t  a;
    obs_t  b;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [15:0] dig;
  logic [3:0]  dpi;
  logic [3:0]  bm;

  int tests  = 0;
  int failed = 0;
  exp_t q[$];
  event chk_now;

  always #5 clk = ~clk;

  seg_scan_mux_if #(.NUM_DIGITS(4)) ifa ();
  seg_scan_mux_if #(.NUM_DIGITS(4)) ifb ();

  assign ifa.enable = en;  assign ifa.digits = dig;
  assign ifa.dp_in = dpi;  assign ifa.blink_mask = bm;
  assign ifb.enable = en;  assign ifb.digits = dig;
  assign ifb.dp_in = dpi;  assign ifb.blink_mask = bm;

  seg_scan_mux #(
    .NUM_DIGITS(4), .HEX_EN(1), .BLANK_LZ(1), .BLINK_FRAMES(2)
  ) dut_a (
    .clk_70hz (clk),
    .reset    (reset),
    .bus      (ifa)
  );

  seg_scan_mux #(
    .NUM_DIGITS(4), .HEX_EN(0), .BLANK_LZ(0), .BLINK_FRAMES(16)
  ) dut_b (
    .clk_70hz (clk),
    .reset    (reset),
    .bus      (ifb)
  );

  function automatic obs_t o(logic [3:0] an, logic [6:0] sg, logic dp, logic fs);
    obs_t r;
    r.an = an; r.sg = sg; r.dp = dp; r.fs = fs;
    return r;
  endfunction

  localparam obs_t IDLE_O = '{an: 4'hF, sg: 7'h7F, dp: 1'b1, fs: 1'b0};

  task automatic cmp(input string nm, input string which, input obs_t got, input obs_t exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s.%s: got anode=%b segs=%h dp_n=%b fs=%b, expected anode=%b segs=%h dp_n=%b fs=%b",
               nm, which, got.an, got.sg, got.dp, got.fs, exp.an, exp.sg, exp.dp, exp.fs);
    end
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or chk_now);
      while (q.size() > 0) begin
        e = q.pop_front();
        cmp(e.name, "A", {ifa.anode, ifa.segs, ifa.dp_n, ifa.frame_start}, e.a);
        cmp(e.name, "B", {ifb.anode, ifb.segs, ifb.dp_n, ifb.frame_start}, e.b);
      end
    end
  end

  task automatic chk_edge(input string nm, input obs_t a, input obs_t b);
    @(posedge clk);
    #1;
    q.push_back('{nm, a, b});
  endtask

  task automatic skip_edge();
    @(posedge clk);
    #1;
  endtask

  // Driver
  initial begin
    logic [6:0] s1234 [4];
    obs_t ea, eb;
    s1234[0] = 7'h19; s1234[1] = 7'h30; s1234[2] = 7'h24; s1234[3] = 7'h79;

    reset = 1'b1; en = 1'b0; dig = '0; dpi = '0; bm = '0;
    #1;
    q.push_back('{"reset_idle", IDLE_O, IDLE_O});
    skip_edge();
    reset = 1'b0; en = 1'b1; dig = 16'h1234;

    // Basic scan
    chk_edge("scan_s0",  o(4'hE, 7'h19, 1, 1), o(4'hE, 7'h19, 1, 1));
    chk_edge("scan_s1",  o(4'hD, 7'h30, 1, 0), o(4'hD, 7'h30, 1, 0));
    chk_edge("scan_s2",  o(4'hB, 7'h24, 1, 0), o(4'hB, 7'h24, 1, 0));
    chk_edge("scan_s3",  o(4'h7, 7'h79, 1, 0), o(4'h7, 7'h79, 1, 0));
    chk_edge("scan_wrap",o(4'hE, 7'h19, 1, 1), o(4'hE, 7'h19, 1, 1));
    dig = 16'h0007;
    // Old snapshot stays visible for the rest of the frame
    chk_edge("hold_s1",  o(4'hD, 7'h30, 1, 0), o(4'hD, 7'h30, 1, 0));
    chk_edge("hold_s2",  o(4'hB, 7'h24, 1, 0), o(4'hB, 7'h24, 1, 0));
    chk_edge("hold_s3",  o(4'h7, 7'h79, 1, 0), o(4'h7, 7'h79, 1, 0));

    // Leading-zero blanking
    chk_edge("lz_s0",    o(4'hE, 7'h78, 1, 1), o(4'hE, 7'h78, 1, 1));
    dig = 16'h0000;
    chk_edge("lz_s1",    o(4'hD, 7'h7F, 1, 0), o(4'hD, 7'h40, 1, 0));
    chk_edge("lz_s2",    o(4'hB, 7'h7F, 1, 0), o(4'hB, 7'h40, 1, 0));
    chk_edge("lz_s3",    o(4'h7, 7'h7F, 1, 0), o(4'h7, 7'h40, 1, 0));
    chk_edge("zero_s0",  o(4'hE, 7'h40, 1, 1), o(4'hE, 7'h40, 1, 1));
    dig = 16'h1234;
    skip_edge(); skip_edge(); skip_edge();

    // Snapshot coherency
    chk_edge("snap_s0",  o(4'hE, 7'h19, 1, 1), o(4'hE, 7'h19, 1, 1));
    chk_edge("snap_s1",  o(4'hD, 7'h30, 1, 0), o(4'hD, 7'h30, 1, 0));
    dig = 16'h9999;
    chk_edge("snap_s2",  o(4'hB, 7'h24, 1, 0), o(4'hB, 7'h24, 1, 0));
    chk_edge("snap_s3",  o(4'h7, 7'h79, 1, 0), o(4'h7, 7'h79, 1, 0));
    chk_edge("snap_new", o(4'hE, 7'h18, 1, 1), o(4'hE, 7'h18, 1, 1));
    dig = 16'h000A;
    skip_edge(); skip_edge(); skip_edge();

    // Hex mode
    chk_edge("hex_s0",   o(4'hE, 7'h08, 1, 1), o(4'hE, 7'h7F, 1, 1));
    dig = 16'h5678;
    chk_edge("hex_s1",   o(4'hD, 7'h7F, 1, 0), o(4'hD, 7'h40, 1, 0));
    skip_edge();

    // Disable at idx=2, then resume with a fresh snapshot
    en = 1'b0;
    chk_edge("disable",  IDLE_O, IDLE_O);
    chk_edge("idle_hold",IDLE_O, IDLE_O);
    en = 1'b1;
    chk_edge("resume_s0",o(4'hE, 7'h00, 1, 1), o(4'hE, 7'h00, 1, 1));
    chk_edge("resume_s1",o(4'hD, 7'h78, 1, 0), o(4'hD, 7'h78, 1, 0));

    // Asynchronous reset between edges
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    q.push_back('{"async_reset", IDLE_O, IDLE_O});
    ->chk_now;
    chk_edge("reset_hold", IDLE_O, IDLE_O);
    reset = 1'b0; dig = 16'h1234; dpi = 4'b0001; bm = 4'b0001;

    // Blink: A blanks slot 0 in frames 2-3; B never blinks within 6 frames
    for (int f = 0; f < 6; f++) begin
      for (int s = 0; s < 4; s++) begin
        eb = o(~(4'b0001 << s), s1234[s], (s != 0), (s == 0));
        ea = eb;
        if (s == 0 && (f == 2 || f == 3)) ea = o(4'hF, 7'h7F, 1, 1);
        chk_edge($sformatf("blink_f%0d_s%0d", f, s), ea, eb);
      end
    end

    en = 1'b0;
    skip_edge();
    @(negedge clk);
    #1;
    tests++;
    if (q.size() != 0) begin
      failed++;
      $display("FAIL drain: got %0d pending expectations, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
